// File: rtl/pwm_cfg_sequencer.sv
// Parameter sequencer for two PWM channels: validates a request, converts duty/phase to clock
// counts with a shared multiply/restoring-divide datapath, and commits at a period boundary.
module pwm_cfg_sequencer #(
   parameter int unsigned W      = 26,
   parameter int unsigned DSCALE = 10000,
   parameter int unsigned PMAX   = 360
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req,
   input  logic         sel,
   input  logic [W-1:0] n,
   input  logic [W-1:0] d,
   input  logic [W-1:0] delay,
   input  logic [1:0]   pend,
   output logic         ack,
   output logic         err,
   output logic         busy,
   output logic [W-1:0] n0,
   output logic [W-1:0] non0,
   output logic [W-1:0] dly0,
   output logic [W-1:0] n1,
   output logic [W-1:0] non1,
   output logic [W-1:0] dly1
);

   localparam int unsigned CW = $clog2(W);

   typedef enum logic [2:0] {
      StIdle, StCheck, StMulOn, StDivOn, StMulDly, StDivDly, StWait, StAck
   } state_e;

   state_e         state_q, state_d;
   logic           sel_q, sel_d;
   logic [W-1:0]   n_q, n_d, d_q, d_d, dly_q, dly_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   non_q, non_d, dlyc_q, dlyc_d;
   logic           err_q, err_d;
   logic [W-1:0]   act_n_q [2];
   logic [W-1:0]   act_n_d [2];
   logic [W-1:0]   act_non_q [2];
   logic [W-1:0]   act_non_d [2];
   logic [W-1:0]   act_dly_q [2];
   logic [W-1:0]   act_dly_d [2];

   logic [W-1:0]   mul_a;
   logic [2*W-1:0] prod;
   logic [W:0]     divisor, shifted, diff;
   logic           ge;
   logic [2*W-1:0] acc_step;
   logic           bad_req, commit_ok;

   assign mul_a = (state_q == StMulOn) ? d_q : dly_q;
   assign prod  = {{W{1'b0}}, mul_a} * {{W{1'b0}}, n_q};

   // Upper half of the product is always below the divisor, so W steps yield the full quotient.
   assign divisor  = (state_q == StDivOn) ? (W+1)'(DSCALE) : (W+1)'(PMAX);
   assign shifted  = {acc_q[2*W-1:W], acc_q[W-1]};
   assign diff     = shifted - divisor;
   assign ge       = (shifted >= divisor);
   assign acc_step = {(ge ? diff[W-1:0] : shifted[W-1:0]), acc_q[W-2:0], ge};

   assign bad_req   = (n_q < W'(2)) || (d_q > W'(DSCALE)) || (dly_q >= W'(PMAX));
   assign commit_ok = pend[sel_q] || (act_n_q[sel_q] == '0);

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      n_d       = n_q;
      d_d       = d_q;
      dly_d     = dly_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      non_d     = non_q;
      dlyc_d    = dlyc_q;
      err_d     = err_q;
      act_n_d   = act_n_q;
      act_non_d = act_non_q;
      act_dly_d = act_dly_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               sel_d   = sel;
               n_d     = n;
               d_d     = d;
               dly_d   = delay;
               err_d   = 1'b0;
               state_d = StCheck;
            end
         end
         StCheck: begin
            err_d   = bad_req;
            state_d = bad_req ? StAck : StMulOn;
         end
         StMulOn: begin
            acc_d   = prod;
            cnt_d   = '0;
            state_d = StDivOn;
         end
         StDivOn: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W-1)) begin
               non_d   = acc_step[W-1:0];
               state_d = StMulDly;
            end
         end
         StMulDly: begin
            acc_d   = prod;
            cnt_d   = '0;
            state_d = StDivDly;
         end
         StDivDly: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W-1)) begin
               dlyc_d  = acc_step[W-1:0];
               state_d = StWait;
            end
         end
         StWait: begin
            // Idle channel (period 0) has no boundary to wait for.
            if (commit_ok) begin
               act_n_d[sel_q]   = n_q;
               act_non_d[sel_q] = non_q;
               act_dly_d[sel_q] = dlyc_q;
               state_d          = StAck;
            end
         end
         StAck: begin
            if (!req) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         sel_q     <= 1'b0;
         n_q       <= '0;
         d_q       <= '0;
         dly_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         non_q     <= '0;
         dlyc_q    <= '0;
         err_q     <= 1'b0;
         act_n_q   <= '{default: '0};
         act_non_q <= '{default: '0};
         act_dly_q <= '{default: '0};
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         n_q       <= n_d;
         d_q       <= d_d;
         dly_q     <= dly_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         non_q     <= non_d;
         dlyc_q    <= dlyc_d;
         err_q     <= err_d;
         act_n_q   <= act_n_d;
         act_non_q <= act_non_d;
         act_dly_q <= act_dly_d;
      end
   end

   assign ack  = (state_q == StAck);
   assign err  = ack & err_q;
   assign busy = (state_q != StIdle) && (state_q != StAck);
   assign n0   = act_n_q[0];
   assign non0 = act_non_q[0];
   assign dly0 = act_dly_q[0];
   assign n1   = act_n_q[1];
   assign non1 = act_non_q[1];
   assign dly1 = act_dly_q[1];

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Scoreboard bench for pwm_cfg_sequencer: expected active registers are queued per request
// and compared when ack rises.
module tb_pwm_cfg_sequencer;

   localparam int unsigned W = 26;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req = 1'b0;
   logic         sel = 1'b0;
   logic [W-1:0] n = '0, d = '0, delay = '0;
   logic [1:0]   pend = 2'b00;
   logic         ack, err, busy;
   logic [W-1:0] n0, non0, dly0, n1, non1, dly1;

   pwm_cfg_sequencer #(.W(W), .DSCALE(10000), .PMAX(360)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .n(n), .d(d), .delay(delay),
      .pend(pend), .ack(ack), .err(err), .busy(busy),
      .n0(n0), .non0(non0), .dly0(dly0), .n1(n1), .non1(non1), .dly1(dly1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         err;
      logic [W-1:0] n0, non0, dly0, n1, non1, dly1;
   } exp_t;

   exp_t         sb_q[$];
   logic [W-1:0] m_n [2];
   logic [W-1:0] m_non [2];
   logic [W-1:0] m_dly [2];
   int           n_tests = 0;
   int           n_fail = 0;
   logic         ack_prev = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         m_n[i] = '0; m_non[i] = '0; m_dly[i] = '0;
      end
   endtask

   // Pops the scoreboard on every ack rising edge.
   always @(negedge clk) begin
      if (rst_n && ack && !ack_prev) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_ack", 64'(1), 64'(0));
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("err",  64'(err),  64'(e.err));
            check_eq("n0",   64'(n0),   64'(e.n0));
            check_eq("non0", 64'(non0), 64'(e.non0));
            check_eq("dly0", 64'(dly0), 64'(e.dly0));
            check_eq("n1",   64'(n1),   64'(e.n1));
            check_eq("non1", 64'(non1), 64'(e.non1));
            check_eq("dly1", 64'(dly1), 64'(e.dly1));
         end
      end
      ack_prev <= ack;
   end

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 1'b0;
      pend  = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_model();
   endtask

   // Called at a negedge; the next posedge is e0. p0e/p1e: edge index of pend pulses (-1 none).
   task automatic run_req(input logic s, input logic [W-1:0] nn, input logic [W-1:0] dd,
                          input logic [W-1:0] dl, input int p0e, input int p1e,
                          input int exp_edge, input int hold);
      logic        bad;
      logic [63:0] t;
      exp_t        e;
      int          got_edge;
      logic        busy_ok;
      logic        ack_held;
      bad = (nn < 2) || (dd > 10000) || (dl >= 360);
      if (!bad) begin
         m_n[s] = nn;
         t = 64'(dd) * 64'(nn) / 64'd10000;
         m_non[s] = t[W-1:0];
         t = 64'(dl) * 64'(nn) / 64'd360;
         m_dly[s] = t[W-1:0];
      end
      e = '{err: bad, n0: m_n[0], non0: m_non[0], dly0: m_dly[0],
            n1: m_n[1], non1: m_non[1], dly1: m_dly[1]};
      sb_q.push_back(e);
      req = 1'b1; sel = s; n = nn; d = dd; delay = dl;
      got_edge = -1;
      busy_ok  = 1'b1;
      for (int k = 0; k < 400 && got_edge < 0; k++) begin
         pend[0] = (k == p0e);
         pend[1] = (k == p1e);
         @(negedge clk);
         if (k == 0) begin
            sel = ~s; n = W'($urandom); d = W'($urandom); delay = W'($urandom);
         end
         if (ack) got_edge = k;
         else if (!busy) busy_ok = 1'b0;
      end
      pend = 2'b00;
      check_eq("ack_edge", 64'(got_edge), 64'(exp_edge));
      check_eq("busy_during", 64'(busy_ok), 64'(1));
      if (got_edge < 0) begin
         void'(sb_q.pop_back());
         do_reset();
      end else begin
         check_eq("busy_at_ack", 64'(busy), 64'(0));
         if (hold > 0) begin
            ack_held = 1'b1;
            repeat (hold) begin
               @(negedge clk);
               ack_held &= ack;
            end
            check_eq("ack_held", 64'(ack_held), 64'(1));
            check_eq("hold_n0", 64'(n0), 64'(m_n[0]));
         end
         req = 1'b0;
         @(negedge clk);
         check_eq("ack_fall", 64'(ack), 64'(0));
      end
   endtask

   initial begin
      clear_model();
      repeat (2) @(negedge clk);
      check_eq("rst_ack",  64'(ack),  64'(0));
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_outs", 64'({n0, non0, dly0, n1, non1, dly1} == '0), 64'(1));
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", 64'(busy), 64'(0));

      // Idle channels commit at e56.
      run_req(1'b0, W'(1666), W'(2550), W'(0), -1, -1, 56, 0);
      run_req(1'b1, W'(1666), W'(2550), W'(0), -1, -1, 56, 0);
      // Active ch1: ch0 strobe ignored, commit on ch1 strobe.
      run_req(1'b1, W'(1666), W'(8770), W'(270), 60, 100, 100, 0);
      // Rejections.
      run_req(1'b0, W'(1666), W'(10001), W'(0), -1, -1, 1, 0);
      run_req(1'b0, W'(1), W'(5000), W'(0), -1, -1, 1, 0);
      run_req(1'b1, W'(1666), W'(5000), W'(360), -1, -1, 1, 0);
      // Boundaries.
      run_req(1'b0, W'(1000), W'(10000), W'(0), 70, -1, 70, 0);
      run_req(1'b0, W'(1000), W'(0), W'(0), 57, -1, 57, 0);
      run_req(1'b1, W'(360), W'(5000), W'(359), -1, 56, 56, 0);
      run_req(1'b1, W'(67108863), W'(10000), W'(359), -1, 80, 80, 0);
      run_req(1'b0, W'(2), W'(9999), W'(1), 60, -1, 60, 0);
      // Held request: one commit only, then a fresh request.
      run_req(1'b0, W'(1666), W'(5000), W'(180), 56, -1, 56, 200);
      run_req(1'b0, W'(3000), W'(1234), W'(45), 90, -1, 90, 0);

      // Reset mid-division.
      req = 1'b1; sel = 1'b0; n = W'(5000); d = W'(5000); delay = W'(90);
      repeat (15) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_busy", 64'(busy), 64'(0));
      check_eq("midrst_ack",  64'(ack),  64'(0));
      check_eq("midrst_ch0",  64'({n0, non0, dly0} == '0), 64'(1));
      check_eq("midrst_ch1",  64'({n1, non1, dly1} == '0), 64'(1));
      req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_model();
      @(negedge clk);
      run_req(1'b0, W'(1666), W'(2550), W'(0), -1, -1, 56, 0);

      check_eq("sb_drain", 64'(sb_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_cfg_sequencer.md
# pwm_cfg_sequencer

Sequencing controller that owns the parameter registers of the two PWM channels. It accepts a request carrying period N, duty D in 0.01 % units and phase delay in degrees. It converts D and delay into clock counts with a shared sequential multiply/divide datapath. The new values are committed to the selected channel only at that channel's period boundary, so a running waveform never sees a torn update.

## Interface
- W, 26, width of N and of every count output
- DSCALE, 10000, full-scale duty (D = 10000 means 100 %)
- PMAX, 360, phase full scale in degrees

- iCLK  in  1  system clock (50 MHz domain of the PWM channels)
- iRST  in  1  reset; one clock; reset is asynchronous and active-low
- iREQ  in  1  update request, level; held until oACK seen
- iSEL  in  1  target channel (0/1), sampled with iREQ
- iN  in  W  period in clocks
- iD  in  W  duty, 0..DSCALE
- iDELAY  in  W  phase, 0..PMAX-1
- iPEND  in  2  per-channel period-start strobe, 1 clock wide, from PWM channels
- oACK  out  1  request done (4-phase handshake)
- oERR  out  1  request rejected; valid while oACK=1
- oBUSY  out  1  conversion or commit in progress
- oN0, oNON0, oDLY0  out  W each  channel 0 active period, on-count, delay-count
- oN1, oNON1, oDLY1  out  W each  channel 1 active values

## Operation
- Reset: every output 0; state IDLE; shadow registers 0.
- IDLE: when iREQ=1, capture iSEL/iN/iD/iDELAY into shadow; go to CHECK.
- CHECK: reject if iN<2, iD>DSCALE or iDELAY>=PMAX; go to ACK with oERR=1, active regs untouched. Otherwise go to MUL_ON.
- MUL_ON: P = D*N (2W-bit register); go to DIV_ON.
- DIV_ON: restoring divide P/DSCALE, one quotient bit per clock, W iterations. Result NON = floor(D*N/DSCALE), which is <= N. Go to MUL_DLY.
- MUL_DLY: P = DELAY*N; go to DIV_DLY.
- DIV_DLY: W iterations, DLY = floor(DELAY*N/PMAX); go to WAIT.
- WAIT: commit shadow N/NON/DLY to the target channel's active regs on the first edge where iPEND[sel]=1. The other channel's strobe is ignored. If the target's active oN is 0 (channel idle), commit on the next edge unconditionally. Go to ACK.
- ACK: oACK=1 (oERR as decided); hold until iREQ=0, then IDLE. A held iREQ never retriggers.
- oBUSY=1 in CHECK..WAIT, 0 in IDLE and ACK.
- Input changes after capture are ignored. iREQ outside IDLE is ignored.
- Reset asserted in any state: immediate return to the reset values above, including the active regs. No partial commit.

## Timing
- Edge e0: iREQ sampled in IDLE.
- Edge e1: CHECK decides; on error oACK=1 after e1.
- Edge e2: MUL_ON. Edges e3..e28: DIV_ON. Edge e29: MUL_DLY. Edges e30..e55: DIV_DLY.
- WAIT entered at e55. Minimum commit edge is e56, or the first later edge with iPEND[sel]=1.
- Active regs and oACK change on the same commit edge. All three regs of a channel change together.
- oACK falls one edge after iREQ is sampled low.
- Arithmetic is unsigned and floor-rounded. Product width is 2W; the quotient fits W bits because D<=DSCALE and DELAY<PMAX.

## Test plan
- Ch0, N=1666, D=2550, DELAY=0, channel idle -> commit at e56: oN0=1666, oNON0=424, oDLY0=0; ch1 outputs stay 0.
- Ch1 active (oN1=1666), request N=1666, D=8770, DELAY=270. Pulse iPEND[0] at e60 and iPEND[1] at e100 -> oN1=1666, oNON1=1461, oDLY1=1249 at e100 exactly; oBUSY=1 until then.
- D=10001 (also N=1, DELAY=360 separately) -> oACK with oERR=1 after e1; all active outputs unchanged.
- Boundary values: D=10000, N=1000 -> NON=1000; D=0 -> NON=0; DELAY=359, N=360 -> DLY=359.
- iREQ held high 200 clocks after oACK -> exactly one commit; oACK drops one edge after iREQ low. A second request is then accepted normally.
- Assert iRST at e15 (mid DIV_ON) after a prior ch0 commit -> all outputs 0 immediately, oBUSY=0. The next request completes with correct values.
